// File: rtl/cpu_io_pkg.sv
// Shared CPU I/O definitions: datapath width and the input feeder FSM encoding.
package cpu_io_pkg;

    localparam int IO_WIDTH = 36;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/cpu_input_feeder_if.sv
// Host-write / CPU-read bundle for cpu_input_feeder.
// Optional statistics outputs exist only when CPU_INPUT_FEEDER_STATS_EN is defined.
interface cpu_input_feeder_if
    import cpu_io_pkg::*;
#(
    parameter int WIDTH        = IO_WIDTH,
    parameter int ADDRESSWIDTH = 4
);
    logic                    wrEn;
    logic [WIDTH-1:0]        wrData;
    logic                    full;
    logic                    overflow;
    logic                    inRequest;
    logic                    inValid;
    logic [WIDTH-1:0]        inData;
    logic [ADDRESSWIDTH:0]   level;
`ifdef CPU_INPUT_FEEDER_STATS_EN
    logic [15:0]             deliveredCount;
    logic [15:0]             starvedCycles;

    modport master (
        output wrEn, wrData, inRequest,
        input  full, overflow, inValid, inData, level, deliveredCount, starvedCycles
    );
    modport slave (
        input  wrEn, wrData, inRequest,
        output full, overflow, inValid, inData, level, deliveredCount, starvedCycles
    );
`else
    modport master (
        output wrEn, wrData, inRequest,
        input  full, overflow, inValid, inData, level
    );
    modport slave (
        input  wrEn, wrData, inRequest,
        output full, overflow, inValid, inData, level
    );
`endif
endinterface

// File: rtl/cpu_io_fifo.sv
// Pointer-based FIFO with a wrap bit and a registered read port (the read
// register holds the last popped word). A pop frees a slot in the same edge.
module cpu_io_fifo
    import cpu_io_pkg::*;
#(
    parameter int WIDTH        = IO_WIDTH,
    parameter int DEPTH        = 16,
    parameter int ADDRESSWIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [ADDRESSWIDTH:0] level,
    output logic                  wr_drop
);
    logic [ADDRESSWIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESSWIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]      rd_data_q, rd_data_d;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic                  do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[ADDRESSWIDTH-1:0] == rd_ptr_q[ADDRESSWIDTH-1:0]) &&
                     (wr_ptr_q[ADDRESSWIDTH] != rd_ptr_q[ADDRESSWIDTH]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign do_pop  = rd_en && !empty;
    // A full FIFO still accepts a write when a pop retires a word on the same edge.
    assign do_push = wr_en && (!full || do_pop);
    assign wr_drop = wr_en && !do_push;
    assign rd_data = rd_data_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q + {{ADDRESSWIDTH{1'b0}}, do_push};
        rd_ptr_d  = rd_ptr_q + {{ADDRESSWIDTH{1'b0}}, do_pop};
        rd_data_d = rd_data_q;
        if (do_pop) begin
            rd_data_d = mem[rd_ptr_q[ADDRESSWIDTH-1:0]];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_q[ADDRESSWIDTH-1:0]] <= wr_data;
        end
    end
endmodule

// File: rtl/cpu_input_feeder.sv
// Delivers host-written words to the CPU one per request through a FIFO.
// Define CPU_INPUT_FEEDER_STATS_EN to add deliveredCount/starvedCycles counters.
module cpu_input_feeder
    import cpu_io_pkg::*;
#(
    parameter int WIDTH        = IO_WIDTH,
    parameter int DEPTH        = 16,
    parameter int ADDRESSWIDTH = 4
) (
    input logic               clock,
    input logic               reset,
    cpu_input_feeder_if.slave bus
);
    feeder_state_t         state_q, state_d;
    logic                  in_valid_q, in_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  pop;
    logic                  empty;
    logic                  full;
    logic                  wr_drop;
    logic [WIDTH-1:0]      rd_data;
    logic [ADDRESSWIDTH:0] level;

    cpu_io_fifo #(
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .ADDRESSWIDTH (ADDRESSWIDTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (bus.wrEn),
        .wr_data (bus.wrData),
        .rd_en   (pop),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .level   (level),
        .wr_drop (wr_drop)
    );

    // WAIT remembers a request made against an empty FIFO; RESP enforces the re-request gap.
    always_comb begin
        state_d    = state_q;
        in_valid_d = 1'b0;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.inRequest) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        in_valid_d = 1'b1;
                        state_d    = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!empty) begin
                    pop        = 1'b1;
                    in_valid_d = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        overflow_d = overflow_q | wr_drop;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            in_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_valid_q <= in_valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.full     = full;
    assign bus.overflow = overflow_q;
    assign bus.inValid  = in_valid_q;
    assign bus.inData   = rd_data;
    assign bus.level    = level;

`ifdef CPU_INPUT_FEEDER_STATS_EN
    logic [15:0] delivered_q, delivered_d;
    logic [15:0] starved_q, starved_d;

    always_comb begin
        delivered_d = delivered_q;
        starved_d   = starved_q;
        if (pop && (delivered_q != 16'hFFFF)) begin
            delivered_d = delivered_q + 16'd1;
        end
        if ((state_q == WAIT) && (starved_q != 16'hFFFF)) begin
            starved_d = starved_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            delivered_q <= '0;
            starved_q   <= '0;
        end else begin
            delivered_q <= delivered_d;
            starved_q   <= starved_d;
        end
    end

    assign bus.deliveredCount = delivered_q;
    assign bus.starvedCycles  = starved_q;
`endif
endmodule

// File: tb/tb_cpu_input_feeder.sv
// Directed bench for cpu_input_feeder: a vector table plus hand-written
// sequences for reset, starvation, overflow, wrap and ignored requests.
module tb_cpu_input_feeder;
    import cpu_io_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    cpu_input_feeder_if #(.WIDTH(36), .ADDRESSWIDTH(4)) bus ();

    cpu_input_feeder #(.WIDTH(36), .DEPTH(16), .ADDRESSWIDTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        wr;
        logic [35:0] data;
        logic        req;
        logic        ev;
        logic [35:0] ed;
        logic [4:0]  el;
        logic        ef;
        logic        eo;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [35:0] v);
        bus.wrEn   = 1'b1;
        bus.wrData = v;
        tick();
        bus.wrEn   = 1'b0;
    endtask

    task automatic req_pop(input string nm, input logic [35:0] exp);
        bus.inRequest = 1'b1;
        tick();
        bus.inRequest = 1'b0;
        chk({nm, "_valid"}, bus.inValid, 1'b1);
        chk({nm, "_data"}, bus.inData, exp);
        $display("pop %s: data=%0h level=%0d", nm, bus.inData, bus.level);
        tick();
    endtask

`ifdef CPU_INPUT_FEEDER_STATS_EN
    logic [15:0] starved_base, delivered_base;
`endif

    initial begin
        bus.wrEn      = 1'b0;
        bus.wrData    = '0;
        bus.inRequest = 1'b0;
        reset         = 1'b1;

        // Ordered delivery, then push/pop overlap including a starved request.
        vecs[0]  = '{1'b1, 36'h1,          1'b0, 1'b0, 36'h0,          5'd1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 36'h2,          1'b0, 1'b0, 36'h0,          5'd2, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 36'hF_FFFF_FFFF, 1'b0, 1'b0, 36'h0,         5'd3, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 36'h0,          1'b1, 1'b1, 36'h1,          5'd2, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 36'h0,          1'b0, 1'b0, 36'h1,          5'd2, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 36'h0,          1'b1, 1'b1, 36'h2,          5'd1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 36'h0,          1'b0, 1'b0, 36'h2,          5'd1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 36'h0,          1'b1, 1'b1, 36'hF_FFFF_FFFF, 5'd0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 36'h0,          1'b0, 1'b0, 36'hF_FFFF_FFFF, 5'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 36'h5,          1'b1, 1'b0, 36'hF_FFFF_FFFF, 5'd1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 36'h0,          1'b0, 1'b1, 36'h5,          5'd0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 36'h6,          1'b1, 1'b0, 36'h5,          5'd1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 36'h7,          1'b1, 1'b1, 36'h6,          5'd1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 36'h0,          1'b0, 1'b0, 36'h6,          5'd1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 36'h0,          1'b1, 1'b1, 36'h7,          5'd0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 36'h0,          1'b0, 1'b0, 36'h7,          5'd0, 1'b0, 1'b0};

        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", bus.inValid, 1'b0);
        chk("rst_data", bus.inData, 36'h0);
        chk("rst_level", bus.level, 5'd0);
        chk("rst_full", bus.full, 1'b0);
        chk("rst_ovf", bus.overflow, 1'b0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) begin
            bus.wrEn      = vecs[i].wr;
            bus.wrData    = vecs[i].data;
            bus.inRequest = vecs[i].req;
            tick();
            $display("vec %0d: wr=%0b req=%0b -> valid=%0b data=%0h level=%0d",
                     i, vecs[i].wr, vecs[i].req, bus.inValid, bus.inData, bus.level);
            chk($sformatf("vec%0d_valid", i), bus.inValid, vecs[i].ev);
            chk($sformatf("vec%0d_data", i), bus.inData, vecs[i].ed);
            chk($sformatf("vec%0d_level", i), bus.level, vecs[i].el);
            chk($sformatf("vec%0d_full", i), bus.full, vecs[i].ef);
            chk($sformatf("vec%0d_ovf", i), bus.overflow, vecs[i].eo);
        end
        bus.wrEn      = 1'b0;
        bus.inRequest = 1'b0;
        tick();

        // Starved request: one-cycle pulse on an empty FIFO, data arrives later.
`ifdef CPU_INPUT_FEEDER_STATS_EN
        starved_base   = bus.starvedCycles;
        delivered_base = bus.deliveredCount;
`endif
        bus.inRequest = 1'b1;
        tick();
        bus.inRequest = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("starve_idle%0d", k), bus.inValid, 1'b0);
        end
        wr(36'hA);
        chk("starve_wr_edge_valid", bus.inValid, 1'b0);
        chk("starve_wr_edge_level", bus.level, 5'd1);
        tick();
        chk("starve_valid", bus.inValid, 1'b1);
        chk("starve_data", bus.inData, 36'hA);
        $display("starved request delivered data=%0h", bus.inData);
`ifdef CPU_INPUT_FEEDER_STATS_EN
        chk("starve_cycles", bus.starvedCycles - starved_base, 16'd7);
        chk("starve_delivered", bus.deliveredCount - delivered_base, 16'd1);
`endif
        tick();
        chk("starve_valid_drop", bus.inValid, 1'b0);

        // Pointer wrap: 40 write/read pairs.
        for (int i = 0; i < 40; i++) begin
            wr(36'(i));
            req_pop($sformatf("wrap%0d", i), 36'(i));
        end
        chk("wrap_level", bus.level, 5'd0);
        chk("wrap_ovf", bus.overflow, 1'b0);

        // Continuous request: one pulse per two cycles, then parked in WAIT.
        for (int i = 0; i < 4; i++) wr(36'(100 + i));
        bus.inRequest = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("hold%0d_valid", k), bus.inValid, ((k % 2) == 0) && (k < 8));
            if (((k % 2) == 0) && (k < 8)) begin
                chk($sformatf("hold%0d_data", k), bus.inData, 36'(100 + k / 2));
            end
            $display("hold cycle %0d: valid=%0b data=%0h", k, bus.inValid, bus.inData);
        end
        bus.inRequest = 1'b0;
        tick();
        chk("hold_wait_valid", bus.inValid, 1'b0);
        wr(36'h99);
        chk("hold_wake_wr_valid", bus.inValid, 1'b0);
        tick();
        chk("hold_wake_valid", bus.inValid, 1'b1);
        chk("hold_wake_data", bus.inData, 36'h99);
        tick();

        // Full and overflow: 17 writes, last one dropped.
        for (int i = 0; i < 17; i++) begin
            wr(36'(i));
            $display("fill %0d: level=%0d full=%0b ovf=%0b", i, bus.level, bus.full, bus.overflow);
            if (i == 15) begin
                chk("fill16_full", bus.full, 1'b1);
                chk("fill16_level", bus.level, 5'd16);
                chk("fill16_ovf", bus.overflow, 1'b0);
            end
        end
        chk("fill17_full", bus.full, 1'b1);
        chk("fill17_level", bus.level, 5'd16);
        chk("fill17_ovf", bus.overflow, 1'b1);
        for (int j = 0; j < 16; j++) req_pop($sformatf("drain%0d", j), 36'(j));
        chk("drain_level", bus.level, 5'd0);
        chk("drain_full", bus.full, 1'b0);
        chk("drain_ovf_sticky", bus.overflow, 1'b1);

        // Reset asserted mid-WAIT aborts the request.
        bus.inRequest = 1'b1;
        tick();
        bus.inRequest = 1'b0;
        tick();
        chk("rwait_valid", bus.inValid, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("rwait_async_ovf", bus.overflow, 1'b0);
        chk("rwait_async_level", bus.level, 5'd0);
        tick();
        tick();
        reset = 1'b0;
        wr(36'h1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rwait_novalid%0d", k), bus.inValid, 1'b0);
            tick();
        end
        chk("rwait_level", bus.level, 5'd1);
        chk("rwait_ovf", bus.overflow, 1'b0);
        req_pop("rwait_drain", 36'h1);

        // Push and pop on the same edge while full: accepted, no overflow.
        for (int i = 0; i < 16; i++) wr(36'(200 + i));
        chk("fullpp_pre_full", bus.full, 1'b1);
        bus.wrEn      = 1'b1;
        bus.wrData    = 36'(216);
        bus.inRequest = 1'b1;
        tick();
        bus.wrEn      = 1'b0;
        bus.inRequest = 1'b0;
        $display("full push+pop: data=%0h level=%0d ovf=%0b", bus.inData, bus.level, bus.overflow);
        chk("fullpp_valid", bus.inValid, 1'b1);
        chk("fullpp_data", bus.inData, 36'(200));
        chk("fullpp_level", bus.level, 5'd16);
        chk("fullpp_full", bus.full, 1'b1);
        chk("fullpp_ovf", bus.overflow, 1'b0);
        tick();
        for (int j = 1; j <= 16; j++) req_pop($sformatf("fullpp_drain%0d", j), 36'(200 + j));
        chk("fullpp_end_level", bus.level, 5'd0);
        chk("fullpp_end_ovf", bus.overflow, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
